// File: rtl/ipsxe_floating_point_pkg.sv
// Shared definitions for the floating-point example-design op sequencer:
// FSM states, ROM entry field positions and the operand LFSR polynomial.
package ipsxe_floating_point_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StIssue,
    StWaitRes,
    StFin
  } state_e;

  localparam int unsigned OP_SEL_MSB = 5;
  localparam int unsigned OP_SEL_LSB = 3;
  localparam int unsigned RND_MSB    = 2;
  localparam int unsigned RND_LSB    = 1;
  localparam int unsigned STOP_BIT   = 0;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois tap mask
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/ipsxe_floating_point_lfsr.sv
// Right-shifting Galois LFSR; advances one step per cycle while step is high.
module ipsxe_floating_point_lfsr #(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(1),
  parameter logic [WIDTH-1:0]  POLY  = WIDTH'(32'h8020_0003)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else if (step) begin
      value <= (value >> 1) ^ (value[0] ? POLY : '0);
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_op_sequencer.sv
// Walks the operation ROM, issues one op per entry to the FP core and folds
// results into an XOR checksum. Define IPSXE_FLOATING_POINT_OPSEQ_LOOP_EN to
// make runs repeat forever after the first start.
module ipsxe_floating_point_op_sequencer
  import ipsxe_floating_point_pkg::*;
#(
  parameter int unsigned NUM_OPS = 16,
  parameter int unsigned OPD_W   = 32,
  parameter logic [31:0] SEED_A  = 32'h1,
  parameter logic [31:0] SEED_B  = 32'h2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [3:0]       rd_addr,
  input  logic [7:0]       dout,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [2:0]       op_sel,
  output logic [1:0]       rnd_mode,
  output logic [OPD_W-1:0] opa,
  output logic [OPD_W-1:0] opb,
  input  logic             res_valid,
  input  logic [OPD_W-1:0] res_data,
  output logic             busy,
  output logic             done,
  output logic [OPD_W-1:0] checksum,
  output logic             proto_err
);

  localparam logic [3:0] LAST_ADDR = 4'(NUM_OPS - 1);

  state_e      state;
  logic        stop;
  logic        lfsr_step;
  logic [31:0] lfsr_a;
  logic [31:0] lfsr_b;
  logic        unused_rsvd;

  assign unused_rsvd = ^dout[7:6];
  assign lfsr_step   = (state == StIssue) && op_valid && op_ready;

  ipsxe_floating_point_lfsr #(
    .WIDTH (32),
    .SEED  (SEED_A),
    .POLY  (LFSR_POLY)
  ) u_lfsr_a (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .value (lfsr_a)
  );

  ipsxe_floating_point_lfsr #(
    .WIDTH (32),
    .SEED  (SEED_B),
    .POLY  (LFSR_POLY)
  ) u_lfsr_b (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .value (lfsr_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      rd_addr   <= '0;
      op_valid  <= 1'b0;
      op_sel    <= '0;
      rnd_mode  <= '0;
      stop      <= 1'b0;
      opa       <= OPD_W'(SEED_A);
      opb       <= OPD_W'(SEED_B);
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
      proto_err <= 1'b0;
    end else begin
      done <= 1'b0;
      // A result strobe outside WAIT_RES is flagged and otherwise dropped.
      if (res_valid && (state != StWaitRes)) begin
        proto_err <= 1'b1;
      end
      case (state)
        StIdle: begin
          if (start) begin
            checksum <= '0;
            rd_addr  <= '0;
            busy     <= 1'b1;
            state    <= StFetch;
          end
        end
        StFetch: begin
          state <= StLoad;
        end
        StLoad: begin
          op_sel   <= dout[OP_SEL_MSB:OP_SEL_LSB];
          rnd_mode <= dout[RND_MSB:RND_LSB];
          stop     <= dout[STOP_BIT];
          opa      <= OPD_W'(lfsr_a);
          opb      <= OPD_W'(lfsr_b);
          op_valid <= 1'b1;
          state    <= StIssue;
        end
        StIssue: begin
          if (op_valid && op_ready) begin
            op_valid <= 1'b0;
            state    <= StWaitRes;
          end
        end
        StWaitRes: begin
          if (res_valid) begin
            checksum <= checksum ^ res_data;
            if (stop || (rd_addr == LAST_ADDR)) begin
              done  <= 1'b1;
              state <= StFin;
            end else begin
              rd_addr <= rd_addr + 4'd1;
              state   <= StFetch;
            end
          end
        end
        StFin: begin
`ifdef IPSXE_FLOATING_POINT_OPSEQ_LOOP_EN
          // Checksum of the finished pass stays visible while done pulses.
          rd_addr  <= '0;
          checksum <= '0;
          state    <= StFetch;
`else
          busy  <= 1'b0;
          state <= StIdle;
`endif
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_op_sequencer.sv
// Self-checking bench: ROM and FP-core models plus an op scoreboard fed from
// an independent LFSR/ROM model of the expected operation stream.
module tb_ipsxe_floating_point_op_sequencer;

  localparam int unsigned NUM_OPS = 16;
  localparam int unsigned OPD_W   = 32;
  localparam logic [31:0] SEED_A  = 32'h1;
  localparam logic [31:0] SEED_B  = 32'h2;
  localparam int          RES_LAT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       rd_addr;
  logic [7:0]       dout = 8'h00;
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_sel;
  logic [1:0]       rnd_mode;
  logic [OPD_W-1:0] opa;
  logic [OPD_W-1:0] opb;
  logic             res_valid;
  logic [OPD_W-1:0] res_data;
  logic             busy;
  logic             done;
  logic [OPD_W-1:0] checksum;
  logic             proto_err;

  always #5 clk = ~clk;

  ipsxe_floating_point_op_sequencer #(
    .NUM_OPS (NUM_OPS),
    .OPD_W   (OPD_W),
    .SEED_A  (SEED_A),
    .SEED_B  (SEED_B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_addr   (rd_addr),
    .dout      (dout),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_sel    (op_sel),
    .rnd_mode  (rnd_mode),
    .opa       (opa),
    .opb       (opb),
    .res_valid (res_valid),
    .res_data  (res_data),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .proto_err (proto_err)
  );

  // ROM model with one-cycle registered read
  logic [7:0] rom [16];
  always @(posedge clk) dout <= rom[rd_addr];

  typedef struct packed {
    logic [3:0]  addr;
    logic [2:0]  sel;
    logic [1:0]  rnd;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  op_t         exp_q[$];
  logic [31:0] mdl_a, mdl_b;
  logic [31:0] exp_cksum;
  logic [31:0] pend_res;
  int          resp_cnt = -1;
  logic        inject   = 1'b0;
  int          hs_cnt, done_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) begin
      n[31] = ~n[31];
      n[21] = ~n[21];
      n[1]  = ~n[1];
      n[0]  = ~n[0];
    end
    return n;
  endfunction

  function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] sel);
    return (a * 32'd3) ^ {b[15:0], b[31:16]} ^ {29'd0, sel};
  endfunction

  // Push the expected op stream for one run from the ROM and LFSR model.
  task automatic plan_run();
    op_t e;
    for (int i = 0; i < NUM_OPS; i++) begin
      e.addr = 4'(i);
      e.sel  = rom[i][5:3];
      e.rnd  = rom[i][2:1];
      e.a    = mdl_a;
      e.b    = mdl_b;
      exp_q.push_back(e);
      mdl_a = lfsr_next(mdl_a);
      mdl_b = lfsr_next(mdl_b);
      if (rom[i][0]) break;
    end
  endtask

  // Core model and scoreboard consumer, all on the falling edge.
  always @(negedge clk) begin
    op_t e;
    res_valid = 1'b0;
    if (resp_cnt > 0) resp_cnt--;
    if (resp_cnt == 0) begin
      res_valid = 1'b1;
      res_data  = pend_res;
      exp_cksum = exp_cksum ^ pend_res;
      resp_cnt  = -1;
    end else if (inject) begin
      res_valid = 1'b1;
      res_data  = 32'hdead_beef;
      inject    = 1'b0;
    end
    if (!rst && done) done_cnt++;
    if (!rst && op_valid && op_ready) begin
      hs_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL op_unexpected: addr=%0d sel=%0d opa=%h, required no handshake",
                 rd_addr, op_sel, opa);
      end else begin
        e = exp_q.pop_front();
        if ({rd_addr, op_sel, rnd_mode, opa, opb} !== {e.addr, e.sel, e.rnd, e.a, e.b})
          $display("FAIL op_fields: addr=%0d sel=%0d rnd=%0d a=%h b=%h required %0d %0d %0d %h %h",
                   rd_addr, op_sel, rnd_mode, opa, opb, e.addr, e.sel, e.rnd, e.a, e.b);
        else n_pass++;
      end
      pend_res = core_fn(opa, opb, op_sel);
      resp_cnt = RES_LAT;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    resp_cnt = -1;
    inject   = 1'b0;
    exp_q.delete();
    mdl_a = SEED_A;
    mdl_b = SEED_B;
  endtask

  task automatic begin_run();
    exp_cksum = '0;
    hs_cnt    = 0;
    done_cnt  = 0;
    plan_run();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (done_cnt == 0) $display("FAIL done_timeout: no done within %0d cycles", budget);
    else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    start    = 1'b0;
    op_ready = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h08;
    apply_reset();
    repeat (2) tick();
    n_checks++;
    if ({busy, done, op_valid, rd_addr, op_sel, rnd_mode, checksum, proto_err} !== '0)
      $display("FAIL reset_ctrl: busy=%b done=%b vld=%b addr=%0d sel=%0d rnd=%0d ck=%h pe=%b, required all 0",
               busy, done, op_valid, rd_addr, op_sel, rnd_mode, checksum, proto_err);
    else n_pass++;
    n_checks++;
    if ({opa, opb} !== {SEED_A, SEED_B})
      $display("FAIL reset_opnd: opa=%h opb=%h required %h %h", opa, opb, SEED_A, SEED_B);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_run();
    for (int i = 0; i < 16; i++) rom[i] = 8'h08;
    op_ready = 1'b1;
    begin_run();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL full_busy: busy=%b required 1", busy);
    else n_pass++;
    wait_done(400);
    n_checks++;
    if ({hs_cnt, done_cnt} !== {32'(NUM_OPS), 32'd1})
      $display("FAIL full_counts: hs=%0d done=%0d required %0d 1", hs_cnt, done_cnt, NUM_OPS);
    else n_pass++;
    n_checks++;
    if ({rd_addr, busy, 32'(exp_q.size())} !== {4'd15, 1'b0, 32'd0})
      $display("FAIL full_end: addr=%0d busy=%b left=%0d required 15 0 0",
               rd_addr, busy, exp_q.size());
    else n_pass++;
    n_checks++;
    if (checksum !== exp_cksum)
      $display("FAIL full_cksum: got %h required %h", checksum, exp_cksum);
    else n_pass++;
  endtask

  task automatic test_stop_patterns();
    logic [7:0] r;
    for (int i = 0; i < 16; i++) begin
      r = 8'($urandom);
      rom[i] = r & 8'hFE;
    end
    rom[2] = 8'h09;
    op_ready = 1'b1;
    begin_run();
    wait_done(200);
    n_checks++;
    if ({hs_cnt, done_cnt, rd_addr} !== {32'd3, 32'd1, 4'd2})
      $display("FAIL stop_run: hs=%0d done=%0d addr=%0d required 3 1 2", hs_cnt, done_cnt, rd_addr);
    else n_pass++;
    n_checks++;
    if (checksum !== exp_cksum)
      $display("FAIL stop_cksum: got %h required %h", checksum, exp_cksum);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] a0, b0;
    logic [2:0]  s0;
    int          n = 0;
    rom[0] = 8'h11;
    op_ready = 1'b0;
    begin_run();
    while (!op_valid && n < 20) begin
      tick();
      n++;
    end
    a0 = opa;
    b0 = opb;
    s0 = op_sel;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({op_valid, opa, opb, op_sel} !== {1'b1, a0, b0, 3'b010})
        $display("FAIL bp_hold%0d: vld=%b a=%h b=%h sel=%0d required 1 %h %h 2",
                 i, op_valid, opa, opb, op_sel, a0, b0);
      else n_pass++;
    end
    n_checks++;
    if ({hs_cnt, s0} !== {32'd0, 3'b010})
      $display("FAIL bp_nohs: hs=%0d sel=%0d required 0 2", hs_cnt, s0);
    else n_pass++;
    op_ready = 1'b1;
    wait_done(100);
    n_checks++;
    if ({hs_cnt, done_cnt} !== {32'd1, 32'd1})
      $display("FAIL bp_once: hs=%0d done=%0d required 1 1", hs_cnt, done_cnt);
    else n_pass++;
  endtask

  task automatic test_proto_err();
    for (int i = 0; i < 16; i++) rom[i] = 8'h08;
    op_ready = 1'b1;
    begin_run();
    inject = 1'b1;
    tick();
    n_checks++;
    if ({proto_err, checksum} !== {1'b1, 32'd0})
      $display("FAIL proto_flag: pe=%b ck=%h required 1 0", proto_err, checksum);
    else n_pass++;
    wait_done(400);
    n_checks++;
    if ({hs_cnt, done_cnt, proto_err} !== {32'(NUM_OPS), 32'd1, 1'b1})
      $display("FAIL proto_run: hs=%0d done=%0d pe=%b required %0d 1 1",
               hs_cnt, done_cnt, proto_err, NUM_OPS);
    else n_pass++;
    n_checks++;
    if (checksum !== exp_cksum)
      $display("FAIL proto_cksum: got %h required %h", checksum, exp_cksum);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h08;
    op_ready = 1'b1;
    begin_run();
    while (hs_cnt < 7 && n < 200) begin
      tick();
      n++;
    end
    apply_reset();
    #1;
    n_checks++;
    if ({busy, done, op_valid, rd_addr, op_sel, rnd_mode, checksum, proto_err, opa, opb}
        !== {1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 2'd0, 32'd0, 1'b0, SEED_A, SEED_B})
      $display("FAIL mid_reset: busy=%b done=%b vld=%b addr=%0d ck=%h pe=%b a=%h b=%h required reset values",
               busy, done, op_valid, rd_addr, checksum, proto_err, opa, opb);
    else n_pass++;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (done_cnt !== 0) $display("FAIL mid_nodone: done=%0d required 0", done_cnt);
    else n_pass++;
    rom[2] = 8'h09;
    begin_run();
    n = 0;
    while (!op_valid && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if ({opa, opb} !== {SEED_A, SEED_B})
      $display("FAIL mid_reseed: opa=%h opb=%h required %h %h", opa, opb, SEED_A, SEED_B);
    else n_pass++;
    wait_done(200);
    n_checks++;
    if ({hs_cnt, checksum} !== {32'd3, exp_cksum})
      $display("FAIL mid_replay: hs=%0d ck=%h required 3 %h", hs_cnt, checksum, exp_cksum);
    else n_pass++;
  endtask

  task automatic test_start_busy();
    logic [3:0] a0;
    int         n = 0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h08;
    op_ready = 1'b1;
    begin_run();
    while (hs_cnt < 3 && n < 200) begin
      tick();
      n++;
    end
    a0 = rd_addr;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({rd_addr, busy} !== {a0, 1'b1})
      $display("FAIL busy_start: addr=%0d busy=%b required %0d 1", rd_addr, busy, a0);
    else n_pass++;
    wait_done(400);
    n_checks++;
    if ({hs_cnt, done_cnt, checksum} !== {32'(NUM_OPS), 32'd1, exp_cksum})
      $display("FAIL busy_run: hs=%0d done=%0d ck=%h required %0d 1 %h",
               hs_cnt, done_cnt, checksum, NUM_OPS, exp_cksum);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_stop_patterns();
    test_backpressure();
    test_proto_err();
    test_reset_midrun();
    test_start_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ipsxe_floating_point_op_sequencer.md
# ipsxe_floating_point_op_sequencer

Operation sequencer for the floating-point example design. It walks the operation ROM by driving `rd_addr`, decodes each 8-bit entry, and issues one operation with pseudo-random operands to the floating-point core under a valid/ready handshake. It then waits for that operation's result before fetching the next entry. Results are folded into a running XOR checksum that the example-design checker compares.

## Interface
- `NUM_OPS`, 16: entries executed per run (1..16).
- `OPD_W`, 32: operand/result width.
- `SEED_A`, 32'h1, `SEED_B`, 32'h2: LFSR seeds (nonzero).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a run when idle.
- `rd_addr`  out  4  ROM address.
- `dout`  in  8  ROM data, registered in ROM (1-cycle read latency).
- `op_valid`  out  1  operation offered to core.
- `op_ready`  in  1  core accepts operation.
- `op_sel`  out  3  operation code (`dout[5:3]`).
- `rnd_mode`  out  2  rounding mode (`dout[2:1]`).
- `opa`, `opb`  out  OPD_W  operands.
- `res_valid`  in  1  result strobe from core.
- `res_data`  in  OPD_W  result.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `checksum`  out  OPD_W  XOR of all results in current run.
- `proto_err`  out  1  sticky; `res_valid` seen outside WAIT_RES.

## Operation
- ROM entry fields: `[7:6]` reserved, ignored; `[5:3]` op_sel; `[2:1]` rnd_mode; `[0]` stop, which ends the run after this entry's result.
- States: IDLE, FETCH, LOAD, ISSUE, WAIT_RES, FIN.
- IDLE: `start` clears `checksum` and sets `rd_addr`=0, then goes to FETCH. `start` in any other state is ignored.
- FETCH: ROM samples `rd_addr` this cycle. Always goes to LOAD.
- LOAD: `dout` is valid this cycle.
  - Register op_sel, rnd_mode and stop.
  - Load `opa` and `opb` from their LFSRs.
  - Assert `op_valid`; go to ISSUE.
- ISSUE: hold `op_valid` and all op fields stable until `op_valid && op_ready`. On handshake, drop `op_valid`, advance both LFSRs, and go to WAIT_RES.
- WAIT_RES: on `res_valid`, set `checksum ^= res_data`.
  - If stop=1 or `rd_addr`==NUM_OPS-1, go to FIN.
  - Otherwise increment `rd_addr` and go to FETCH.
- FIN: pulse `done` for one cycle.
  - Without LOOP, go to IDLE.
  - With LOOP, see Configuration.
- LFSRs: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, one step per accepted operation. Operands are the LFSR state zero-extended or truncated to OPD_W.
- `busy` = state != IDLE.
- `checksum` holds its value after the run until the next `start`.
- `res_valid` in any state other than WAIT_RES sets `proto_err` and is otherwise ignored. Only `rst` clears `proto_err`.

## Timing
- Reset values (asynchronous):
  - state IDLE; `rd_addr` 0; `op_valid` 0; `op_sel` 0; `rnd_mode` 0; `opa` SEED_A; `opb` SEED_B; `busy` 0; `done` 0; `checksum` 0; `proto_err` 0.
  - Reset mid-run aborts with no `done`, and the LFSRs reseed.
- `start` at edge k puts the FSM in FETCH after edge k+1. `op_valid` rises 2 cycles after any `rd_addr` update.
- Minimum cost per op is 4 cycles (FETCH, LOAD, ISSUE with ready=1, WAIT_RES with same-cycle `res_valid`).
- `done` is asserted the cycle after the last result is accepted.
- `op_ready` high in LOAD has no effect; only ISSUE samples it.

## Configuration
- `IPSXE_FLOATING_POINT_OPSEQ_LOOP_EN` defined:
  - FIN wraps `rd_addr` to 0 and returns to FETCH with no new `start`.
  - `checksum` restarts at 0 each pass, after `done` pulses.
  - LFSRs are not reseeded.
  - `busy` stays 1 until `rst`.
- Undefined: single run per `start`, as described in Operation.

## Structure
- Shared package `ipsxe_floating_point_pkg` holds:
  - state enum;
  - ROM field bit positions (OP_SEL_MSB/LSB, RND_MSB/LSB, STOP_BIT);
  - LFSR polynomial constant.
- One sub-module, `ipsxe_floating_point_lfsr` (width, seed, step enable), instantiated twice.

## Test plan
- ROM all 8'h08, NUM_OPS=16, `op_ready`=1, `res_valid` 3 cycles after each handshake:
  - exactly 16 handshakes, each with op_sel=3'b001 and rnd_mode=0;
  - `rd_addr` steps 0..15;
  - one `done` pulse; `checksum` = XOR of the 16 results.
- Entry 2 = 8'h09 (stop set): 3 operations, then `done`; `rd_addr` ends at 2.
- `op_ready` low for 5 cycles in ISSUE: `op_valid`, `opa`, `opb` and `op_sel` stay constant throughout; exactly one handshake occurs.
- `res_valid` pulsed in FETCH: `proto_err`=1 and `checksum` unchanged; the run still completes normally.
- `rst` asserted while in WAIT_RES on op 7: all outputs return to reset values immediately and no `done` pulses. A subsequent `start` replays the operands from SEED_A and SEED_B.
- `start` pulsed while busy: ignored, with no restart and no change to `rd_addr`.
